// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants and helpers for the mux_scan block
// Purpose: FSM state encodings, mode encodings and the channel-index width helper.
// Ports: none (package).
package mux_scan_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MANUAL = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Channel index width; a single channel still needs one index bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// rtl/mux_nto1.sv - parametrised N-to-1 combinational channel selector
// Purpose: pick one DW-bit slice out of N_CH packed channels.
// Ports:
//   din  - packed channels, channel k at [k*DW +: DW]
//   sel  - channel index
//   dout - selected slice
module mux_nto1
    import mux_scan_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int DW   = 1,
    localparam int SELW = sel_width(N_CH)
) (
    input  logic [N_CH*DW-1:0] din,
    input  logic [SELW-1:0]    sel,
    output logic [DW-1:0]      dout
);

    always_comb begin
        dout = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == k[SELW-1:0]) begin
                dout = din[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered channel multiplexer with manual and auto-scan modes
// Purpose: present one channel of din on dout, chosen by sel (manual) or by a
//          dwell-timed round-robin scan (auto-scan).
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   din        - packed channels, channel k at [k*DW +: DW]
//   sel        - manual channel index
//   mode       - 0 manual, 1 auto-scan
//   en         - advance enable; low freezes everything
//   dout, ch   - registered sample and its channel index
//   dout_valid - dout/ch were updated by the previous enabled cycle
//   wrap       - pulse when the scan returns to channel 0
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int DW    = 1,
    parameter int DWELL = 4,
    localparam int SELW = sel_width(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] din,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    input  logic               en,
    output logic [DW-1:0]      dout,
    output logic [SELW-1:0]    ch,
    output logic               dout_valid,
    output logic               wrap
);

    localparam int CNTW = $clog2(DWELL + 1);

    state_t          state, nxt_state;
    logic [SELW-1:0] idx, nxt_idx;
    logic [CNTW-1:0] cnt, nxt_cnt;
    logic [SELW-1:0] mux_sel;
    logic [DW-1:0]   mux_out;
    logic            nxt_wrap;

    mux_nto1 #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_mux (
        .din  (din),
        .sel  (mux_sel),
        .dout (mux_out)
    );

    // cnt counts samples already taken of the current channel minus one, so
    // the entry sample is the first of DWELL and cnt never exceeds DWELL-1.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        mux_sel   = idx;
        nxt_wrap  = 1'b0;
        if (mode == MODE_MANUAL) begin
            nxt_state = ST_MANUAL;
            nxt_idx   = '0;
            nxt_cnt   = '0;
            mux_sel   = sel;
        end else if (state != ST_SCAN) begin
            nxt_state = ST_SCAN;
            nxt_idx   = '0;
            nxt_cnt   = '0;
            mux_sel   = '0;
        end else if (cnt == CNTW'(DWELL - 1)) begin
            // N_CH is a power of two, so the increment wraps naturally.
            nxt_cnt  = '0;
            nxt_idx  = idx + SELW'(1);
            mux_sel  = nxt_idx;
            nxt_wrap = (idx == SELW'(N_CH - 1));
        end else begin
            nxt_cnt = cnt + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            dout       <= '0;
            ch         <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end else if (en) begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            dout       <= mux_out;
            ch         <= mux_sel;
            dout_valid <= 1'b1;
            wrap       <= nxt_wrap;
        end else begin
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard testbench for mux_scan
module tb_mux_scan;

    typedef struct {
        int dout;
        int ch;
        int valid;
        int wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N_CH=8, DW=1, DWELL=4
    logic       a_rst = 1'b1, a_mode = 1'b0, a_en = 1'b0;
    logic [7:0] a_din = '0;
    logic [2:0] a_sel = '0;
    logic [0:0] a_dout;
    logic [2:0] a_ch;
    logic       a_valid, a_wrap;

    // DUT B: N_CH=2, DW=4, DWELL=1
    logic       b_rst = 1'b1, b_mode = 1'b0, b_en = 1'b0;
    logic [7:0] b_din = '0;
    logic [0:0] b_sel = '0;
    logic [3:0] b_dout;
    logic [0:0] b_ch;
    logic       b_valid, b_wrap;

    mux_scan #(.N_CH(8), .DW(1), .DWELL(4)) dut_a (
        .clk(clk), .rst(a_rst), .din(a_din), .sel(a_sel), .mode(a_mode),
        .en(a_en), .dout(a_dout), .ch(a_ch), .dout_valid(a_valid), .wrap(a_wrap)
    );

    mux_scan #(.N_CH(2), .DW(4), .DWELL(1)) dut_b (
        .clk(clk), .rst(b_rst), .din(b_din), .sel(b_sel), .mode(b_mode),
        .en(b_en), .dout(b_dout), .ch(b_ch), .dout_valid(b_valid), .wrap(b_wrap)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   a_last = 0;
    int   b_last = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step_a(input logic rst, input logic en, input logic mode,
                          input logic [2:0] sel, input logic [7:0] din,
                          input int e_ch, input int e_valid, input int e_wrap);
        exp_t e;
        @(negedge clk);
        a_rst = rst; a_en = en; a_mode = mode; a_sel = sel; a_din = din;
        if (rst)      e.dout = 0;
        else if (!en) e.dout = a_last;
        else          e.dout = int'(din[e_ch]);
        a_last  = e.dout;
        e.ch    = e_ch;
        e.valid = e_valid;
        e.wrap  = e_wrap;
        qa.push_back(e);
    endtask

    task automatic step_b(input logic rst, input logic en, input logic mode,
                          input logic sel, input int e_ch, input int e_valid,
                          input int e_wrap);
        exp_t e;
        @(negedge clk);
        b_rst = rst; b_en = en; b_mode = mode; b_sel = sel; b_din = 8'h96;
        if (rst)      e.dout = 0;
        else if (!en) e.dout = b_last;
        else          e.dout = (e_ch == 1) ? 9 : 6;
        b_last  = e.dout;
        e.ch    = e_ch;
        e.valid = e_valid;
        e.wrap  = e_wrap;
        qb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_dout",  int'(a_dout),  e.dout);
                check("a_ch",    int'(a_ch),    e.ch);
                check("a_valid", int'(a_valid), e.valid);
                check("a_wrap",  int'(a_wrap),  e.wrap);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_dout",  int'(b_dout),  e.dout);
                check("b_ch",    int'(b_ch),    e.ch);
                check("b_valid", int'(b_valid), e.valid);
                check("b_wrap",  int'(b_wrap),  e.wrap);
            end
        end
    end

    initial begin
        // reset wins over en and mode
        step_a(1, 1, 1, 0, 8'hA5, 0, 0, 0);
        // manual mode on 8'hA5 (bits 7..0 = 1010_0101)
        step_a(0, 1, 0, 5, 8'hA5, 5, 1, 0);
        step_a(0, 1, 0, 2, 8'hA5, 2, 1, 0);
        step_a(0, 1, 0, 7, 8'h3C, 7, 1, 0);
        step_a(0, 1, 0, 3, 8'h3C, 3, 1, 0);
        // disabled: hold, mode ignored
        step_a(0, 0, 1, 6, 8'h3C, 3, 0, 0);
        // scan: four samples per channel, wrap when ch returns to 0
        for (int i = 0; i <= 45; i++)
            step_a(0, 1, 1, 3'(i), 8'hA5, (i / 4) % 8, 1, (i == 32) ? 1 : 0);
        // at ch=3 after two dwell cycles: freeze for five cycles
        for (int i = 0; i < 5; i++)
            step_a(0, 0, 1, 0, 8'hA5, 3, 0, 0);
        // dwell resumes: two more at ch 3, then 4, 5, 6
        for (int i = 46; i <= 57; i++)
            step_a(0, 1, 1, 0, 8'hA5, (i / 4) % 8, 1, 0);
        // leave scan from ch 6: immediate manual sample of sel=1
        step_a(0, 1, 0, 1, 8'hA5, 1, 1, 0);
        // re-enter scan: restart at ch 0 with full dwell, run up to ch 7
        for (int j = 0; j <= 28; j++)
            step_a(0, 1, 1, 5, 8'hA5, (j / 4) % 8, 1, 0);
        // reset mid-scan at ch 7 (dout was 1)
        step_a(1, 1, 1, 0, 8'hA5, 0, 0, 0);
        // first enabled cycle after reset enters scan, no wrap
        step_a(0, 1, 1, 0, 8'hA5, 0, 1, 0);

        // DUT B: DWELL=1 alternates every cycle, wrap every second cycle
        step_b(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            step_b(0, 1, 1, 0, i % 2, 1, (i > 0 && i % 2 == 0) ? 1 : 0);
        step_b(0, 0, 1, 0, 0, 0, 0);
        step_b(0, 1, 0, 1, 1, 1, 0);
        step_b(1, 0, 1, 1, 0, 0, 0);

        for (int k = 0; k < 20 && (qa.size() > 0 || qb.size() > 0); k++)
            @(negedge clk);
        if (qa.size() > 0 || qb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", qa.size() + qb.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter N_CH, default 8, number of input channels; power of two, 2..16.
REQ-002 Parameter DW, default 1, bit width of each channel.
REQ-003 Parameter DWELL, default 4, cycles spent on each channel in scan mode; 1..255.
REQ-004 Derived constant SELW = log2(N_CH), channel index width.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 din  input  N_CH*DW  packed channels; channel k occupies bits [k*DW+DW-1 : k*DW].
REQ-008 sel  input  SELW  channel index used in manual mode.
REQ-009 mode  input  1  0 = manual, 1 = auto-scan.
REQ-010 en  input  1  advance enable; low freezes all state and outputs.
REQ-011 dout  output  DW  registered selected channel data.
REQ-012 ch  output  SELW  index of the channel currently presented on dout.
REQ-013 dout_valid  output  1  dout/ch hold a sample taken in the previous enabled cycle.
REQ-014 wrap  output  1  one-cycle pulse when scan returns from channel N_CH-1 to channel 0.

Function
REQ-015 FSM states are IDLE, MANUAL and SCAN; the next state is evaluated only on cycles with en=1.
- IDLE -> MANUAL if mode=0.
- IDLE -> SCAN if mode=1.
- MANUAL <-> SCAN follows mode.
REQ-016 MANUAL: on each enabled cycle, dout <= din slice[sel] and ch <= sel; latency is exactly one cycle.
REQ-017 Entry into SCAN (from IDLE or MANUAL) clears the dwell counter and samples channel 0 on the entry cycle.
REQ-018 SCAN channel dwell:
- Each channel is sampled on every enabled cycle for DWELL enabled cycles.
- On the following enabled cycle, the scan index increments and that channel is sampled.
REQ-019 Scan index N_CH-1 wraps to 0, and wrap=1 for the single cycle in which ch first shows 0 after the wrap; wrap is 0 on initial SCAN entry.
REQ-020 SCAN -> MANUAL: the cycle with mode=0 samples din slice[sel] immediately; the scan index and dwell counter are discarded.
REQ-021 DWELL=1: the channel advances on every enabled cycle.
REQ-022 en=0 behaviour:
- dout, ch, scan index, dwell count and state hold.
- dout_valid=0 and wrap=0 on the next cycle.
- Resuming en=1 continues the dwell count where it stopped.
REQ-023 dout_valid=1 in the cycle after any enabled cycle.
REQ-024 sel and mode are sampled only on enabled cycles; sel is ignored in SCAN.
REQ-025 The dwell counter is ceil(log2(DWELL+1)) bits wide and never exceeds DWELL-1.

Reset
REQ-026 rst=1 at a clock edge forces:
- state = IDLE;
- dout, ch, scan index and dwell counter = 0;
- dout_valid = 0 and wrap = 0.
REQ-027 rst has priority over en and mode, including mid-dwell and mid-scan.
REQ-028 The first enabled cycle after reset behaves as entry from IDLE.

Structure
REQ-029 Package mux_scan_pkg holds:
- the state enumeration (IDLE, MANUAL, SCAN);
- the mode encoding constants;
- the SELW derivation function.
REQ-030 Combinational selection is one parametrised sub-module, mux_nto1 (N_CH, DW): din, sel -> dout, instantiated once, with its sel driven by the FSM-chosen index.
REQ-031 All outputs are driven directly from flops; no combinational path from any input to any output.

Verification
REQ-032 Reset then mode=0, en=1, din={8'hA5 pattern, DW=1}, sel=5:
- dout = din[5] and ch=5 one cycle later;
- changing sel to 2 gives ch=2 on the next cycle.
REQ-033 mode=1, en=1, DWELL=4, N_CH=8:
- ch shows 0 for 4 cycles, then 1, ..., 7;
- ch=0 again after 32 cycles, with wrap=1 exactly that cycle.
REQ-034 In scan at ch=3 after 2 dwell cycles, en=0 for 5 cycles:
- ch stays 3, dout_valid=0;
- after en=1, ch stays 3 for 2 more cycles, then moves to 4.
REQ-035 In scan at ch=6, mode=0 with sel=1:
- next cycle ch=1, dout=din[1], wrap=0;
- mode=1 again restarts at ch=0 with a full dwell.
REQ-036 rst=1 asserted mid-scan at ch=7: next cycle dout=0, ch=0, dout_valid=0, wrap=0.
REQ-037 Parameter sweep N_CH=2, DW=4, DWELL=1: ch alternates 0,1,0,1 with wrap=1 every second cycle, and dout equals the corresponding 4-bit slice.
